// File: rtl/length_entry_ctrl.sv
// Keypad-driven wire length controller: collects a decimal length, converts it
// to a stepper pulse count, then sequences a feed followed by a cut.
module length_entry_ctrl #(
    parameter int unsigned STEPS_PER_MM = 16,
    parameter int unsigned MAX_DIGITS   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_num,
    input  logic        motor_done,
    input  logic        cut_done,
    output logic [13:0] entry_val,
    output logic [13:0] length_mm,
    output logic [31:0] motor_steps,
    output logic        motor_start,
    output logic        motor_abort,
    output logic        cut_req,
    output logic        busy,
    output logic        locked,
    output logic        err
);

    localparam logic [3:0] K_STOP = 4'd10;
    localparam logic [3:0] K_GO   = 4'd11;
    localparam logic [3:0] K_LOCK = 4'd12;
    localparam logic [3:0] K_ENT  = 4'd13;
    localparam logic [3:0] K_ESC  = 4'd14;
    localparam logic [3:0] K_PWR  = 4'd15;

    localparam logic [2:0] COUNT_MAX = 3'(MAX_DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_CUT  = 2'd2
    } state_t;

    state_t      state_q;
    logic [13:0] entry_q;
    logic [13:0] length_q;
    logic [31:0] steps_q;
    logic [2:0]  count_q;
    logic        start_q;
    logic        abort_q;
    logic        cut_q;
    logic        locked_q;
    logic        err_q;

    logic [13:0] entry_d;
    logic [31:0] steps_d;
    logic        key_pwr;
    logic        key_stop;
    logic        key_digit;

    // Next typed value and feed step count; widths cover 9999 * 262143 without overflow.
    always_comb begin
        entry_d   = entry_q * 14'd10 + {10'd0, key_num};
        steps_d   = 32'(length_q) * 32'(STEPS_PER_MM);
        key_pwr   = key_valid && (key_num == K_PWR);
        key_stop  = key_valid && (key_num == K_STOP);
        key_digit = key_valid && (key_num <= 4'd9);
    end

    // Main controller: PWR beats everything, STOP beats the done pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            entry_q  <= '0;
            length_q <= '0;
            steps_q  <= '0;
            count_q  <= '0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            cut_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            if (key_pwr) begin
                // Soft power cycle; only an active feed/cut needs the abort pulse.
                state_q  <= ST_IDLE;
                entry_q  <= '0;
                length_q <= '0;
                steps_q  <= '0;
                count_q  <= '0;
                cut_q    <= 1'b0;
                locked_q <= 1'b0;
                abort_q  <= (state_q != ST_IDLE);
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (key_valid && key_num == K_LOCK) begin
                            locked_q <= ~locked_q;
                        end else if (key_valid && !locked_q) begin
                            if (key_digit) begin
                                if (count_q < COUNT_MAX) begin
                                    entry_q <= entry_d;
                                    count_q <= count_q + 3'd1;
                                end
                            end else if (key_num == K_ESC) begin
                                entry_q <= '0;
                                count_q <= '0;
                            end else if (key_num == K_ENT) begin
                                length_q <= entry_q;
                                entry_q  <= '0;
                                count_q  <= '0;
                            end else if (key_num == K_GO) begin
                                if (length_q == '0) begin
                                    err_q <= 1'b1;
                                end else begin
                                    steps_q <= steps_d;
                                    start_q <= 1'b1;
                                    state_q <= ST_FEED;
                                end
                            end
                        end
                    end
                    ST_FEED: begin
                        if (key_stop) begin
                            state_q <= ST_IDLE;
                            cut_q   <= 1'b0;
                            abort_q <= 1'b1;
                        end else if (motor_done) begin
                            state_q <= ST_CUT;
                            cut_q   <= 1'b1;
                        end
                    end
                    ST_CUT: begin
                        if (key_stop) begin
                            state_q <= ST_IDLE;
                            cut_q   <= 1'b0;
                            abort_q <= 1'b1;
                        end else if (cut_done) begin
                            state_q <= ST_IDLE;
                            cut_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cut_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign entry_val   = entry_q;
    assign length_mm   = length_q;
    assign motor_steps = steps_q;
    assign motor_start = start_q;
    assign motor_abort = abort_q;
    assign cut_req     = cut_q;
    assign busy        = (state_q != ST_IDLE);
    assign locked      = locked_q;
    assign err         = err_q;

endmodule

// File: tb/tb_length_entry_ctrl.sv
// Bench for length_entry_ctrl: a digit-queue behavioural model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_length_entry_ctrl;

    localparam int SPM  = 16;
    localparam int MAXD = 4;

    localparam logic [3:0] K_STOP = 4'd10;
    localparam logic [3:0] K_GO   = 4'd11;
    localparam logic [3:0] K_LOCK = 4'd12;
    localparam logic [3:0] K_ENT  = 4'd13;
    localparam logic [3:0] K_ESC  = 4'd14;
    localparam logic [3:0] K_PWR  = 4'd15;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_num;
    logic        motor_done;
    logic        cut_done;
    logic [13:0] entry_val;
    logic [13:0] length_mm;
    logic [31:0] motor_steps;
    logic        motor_start;
    logic        motor_abort;
    logic        cut_req;
    logic        busy;
    logic        locked;
    logic        err;

    always #5 clk = ~clk;

    length_entry_ctrl #(.STEPS_PER_MM(SPM), .MAX_DIGITS(MAXD)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_num    (key_num),
        .motor_done (motor_done),
        .cut_done   (cut_done),
        .entry_val  (entry_val),
        .length_mm  (length_mm),
        .motor_steps(motor_steps),
        .motor_start(motor_start),
        .motor_abort(motor_abort),
        .cut_req    (cut_req),
        .busy       (busy),
        .locked     (locked),
        .err        (err)
    );

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    // Model state: typed digits kept as a list, phase 0=idle 1=feeding 2=cutting.
    int     m_digits[$];
    int     m_len;
    longint m_steps;
    int     m_phase;
    bit     m_start, m_abort, m_cut, m_locked, m_err;

    function automatic int typed_value();
        int v = 0;
        foreach (m_digits[i]) v = v * 10 + m_digits[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge from the inputs presented to the DUT.
    always @(posedge clk) begin
        m_start = 0;
        m_abort = 0;
        m_err   = 0;
        if (reset) begin
            m_digits.delete();
            m_len = 0; m_steps = 0; m_phase = 0; m_cut = 0; m_locked = 0;
        end else if (key_valid && key_num == K_PWR) begin
            m_abort = (m_phase != 0);
            m_digits.delete();
            m_len = 0; m_steps = 0; m_phase = 0; m_cut = 0; m_locked = 0;
        end else if (m_phase != 0) begin
            if (key_valid && key_num == K_STOP) begin
                m_phase = 0; m_cut = 0; m_abort = 1;
            end else if (m_phase == 1 && motor_done) begin
                m_phase = 2; m_cut = 1;
            end else if (m_phase == 2 && cut_done) begin
                m_phase = 0; m_cut = 0;
            end
        end else if (key_valid) begin
            if (key_num == K_LOCK) m_locked = !m_locked;
            else if (!m_locked) begin
                if (key_num <= 4'd9) begin
                    if (m_digits.size() < MAXD) m_digits.push_back(int'(key_num));
                end else if (key_num == K_ESC) begin
                    m_digits.delete();
                end else if (key_num == K_ENT) begin
                    m_len = typed_value();
                    m_digits.delete();
                end else if (key_num == K_GO) begin
                    if (m_len == 0) m_err = 1;
                    else begin
                        m_steps = longint'(m_len) * SPM;
                        m_start = 1;
                        m_phase = 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("entry_val",   32'(entry_val),   32'(typed_value()));
            chk("length_mm",   32'(length_mm),   32'(m_len));
            chk("motor_steps", motor_steps,      32'(m_steps));
            chk("motor_start", 32'(motor_start), 32'(m_start));
            chk("motor_abort", 32'(motor_abort), 32'(m_abort));
            chk("cut_req",     32'(cut_req),     32'(m_cut));
            chk("busy",        32'(busy),        32'(m_phase != 0));
            chk("locked",      32'(locked),      32'(m_locked));
            chk("err",         32'(err),         32'(m_err));
        end
    end

    // One stimulus cycle: inputs applied at a falling edge, held across one rising edge.
    task automatic drive(input bit kv, input logic [3:0] k, input bit md, input bit cd, input bit rst);
        key_valid = kv; key_num = k; motor_done = md; cut_done = cd; reset = rst;
        @(negedge clk);
        key_valid = 0; key_num = 4'd0; motor_done = 0; cut_done = 0; reset = 0;
    endtask

    task automatic press(input logic [3:0] k);
        drive(1'b1, k, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        key_valid = 0; key_num = 4'd0; motor_done = 0; cut_done = 0; reset = 1;
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        chk("rst_entry",  32'(entry_val), 32'd0);
        chk("rst_steps",  motor_steps,    32'd0);
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_cut",    32'(cut_req),   32'd0);

        // GO with no committed length is rejected.
        press(K_GO);
        chk("go0_err",   32'(err),         32'd1);
        chk("go0_start", 32'(motor_start), 32'd0);
        chk("go0_busy",  32'(busy),        32'd0);
        idle(1);

        // Full feed/cut cycle for 125 mm.
        press(4'd1); press(4'd2); press(4'd5);
        chk("entry_125", 32'(entry_val), 32'd125);
        press(K_ENT);
        chk("len_125",   32'(length_mm), 32'd125);
        chk("ent_clear", 32'(entry_val), 32'd0);
        press(K_GO);
        chk("go_start", 32'(motor_start), 32'd1);
        chk("go_steps", motor_steps,      32'd2000);
        chk("go_busy",  32'(busy),        32'd1);
        idle(1);
        chk("start_one", 32'(motor_start), 32'd0);
        press(4'd7);                       // ignored while feeding
        press(K_LOCK);                     // ignored while feeding
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); // cut_done outside CUT ignored
        chk("feed_hold", 32'(cut_req), 32'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("cut_on", 32'(cut_req), 32'd1);
        idle(2);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("cut_off",   32'(cut_req), 32'd0);
        chk("cut_idle",  32'(busy),    32'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); // motor_done in IDLE ignored
        press(K_STOP);                       // STOP in IDLE has no effect
        chk("stop_idle", 32'(motor_abort), 32'd0);

        // Digit limit and ESC.
        press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(4'd7);
        chk("entry_9999", 32'(entry_val), 32'd9999);
        press(K_ESC);
        chk("esc_clear", 32'(entry_val), 32'd0);
        press(4'd0); press(4'd0); press(4'd4); press(4'd0); press(4'd8);
        chk("lead_zero", 32'(entry_val), 32'd40);

        // STOP coinciding with motor_done during FEED.
        press(K_ESC);
        press(4'd1); press(4'd2); press(4'd5); press(K_ENT);
        press(K_GO);
        idle(1);
        drive(1'b1, K_STOP, 1'b1, 1'b0, 1'b0);
        chk("stopf_abort", 32'(motor_abort), 32'd1);
        chk("stopf_cut",   32'(cut_req),     32'd0);
        chk("stopf_busy",  32'(busy),        32'd0);
        chk("stopf_len",   32'(length_mm),   32'd125);
        idle(2);

        // Keypad lock blocks entry and GO without err.
        press(K_LOCK);
        chk("lock_on", 32'(locked), 32'd1);
        press(4'd5); press(K_ENT); press(K_GO);
        chk("lock_entry", 32'(entry_val),   32'd0);
        chk("lock_start", 32'(motor_start), 32'd0);
        chk("lock_err",   32'(err),         32'd0);
        press(K_LOCK);
        chk("lock_off", 32'(locked), 32'd0);

        // Reset asserted in CUT: no abort pulse.
        press(K_GO);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("rcut_abort", 32'(motor_abort), 32'd0);
        chk("rcut_cut",   32'(cut_req),     32'd0);
        chk("rcut_len",   32'(length_mm),   32'd0);
        chk("rcut_busy",  32'(busy),        32'd0);

        // PWR during FEED aborts and clears.
        press(4'd3); press(K_ENT); press(K_GO);
        chk("feed3_steps", motor_steps, 32'd48);
        press(K_PWR);
        chk("pwr_abort", 32'(motor_abort), 32'd1);
        chk("pwr_steps", motor_steps,      32'd0);
        chk("pwr_busy",  32'(busy),        32'd0);

        // STOP coinciding with cut_done during CUT.
        press(4'd7); press(K_ENT); press(K_GO);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, K_STOP, 1'b0, 1'b1, 1'b0);
        chk("stopc_abort", 32'(motor_abort), 32'd1);
        chk("stopc_cut",   32'(cut_req),     32'd0);
        chk("stopc_steps", motor_steps,      32'd112);

        // PWR in IDLE clears the lock without an abort pulse.
        press(K_LOCK);
        press(K_PWR);
        chk("pwri_lock",  32'(locked),      32'd0);
        chk("pwri_abort", 32'(motor_abort), 32'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/length_entry_ctrl.md
LENGTH_ENTRY_CTRL -- requirements
Module: length_entry_ctrl

Interface
REQ-001 The block SHALL take parameter STEPS_PER_MM, default 16, meaning stepper pulses per millimetre of wire (legal range 1..262143).
REQ-002 The block SHALL take parameter MAX_DIGITS, default 4, meaning the maximum number of decimal digits accepted per entry (legal range 1..4).
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 key_valid  in  1  single-cycle strobe qualifying key_num.
REQ-006 key_num  in  4  key code: 0-9 digit, 10 STOP, 11 GO, 12 LOCK, 13 ENT, 14 ESC, 15 PWR.
REQ-007 motor_done  in  1  single-cycle pulse from the stepper driver: feed complete.
REQ-008 cut_done  in  1  single-cycle pulse from the cutter: cut complete.
REQ-009 entry_val  out  14  decimal value currently being typed.
REQ-010 length_mm  out  14  committed wire length in mm.
REQ-011 motor_steps  out  32  step count for the current feed.
REQ-012 motor_start  out  1  single-cycle feed start pulse.
REQ-013 motor_abort  out  1  single-cycle feed/cut abort pulse.
REQ-014 cut_req  out  1  level, held until cut_done or abort.
REQ-015 busy  out  1  high when state is not IDLE.
REQ-016 locked  out  1  keypad lock status.
REQ-017 err  out  1  single-cycle pulse: GO rejected.

Function
REQ-018 FSM states SHALL be IDLE, FEED and CUT.
REQ-019 Keys SHALL be acted on only in a cycle with key_valid=1; at most one key per cycle.
REQ-020 Digit d in IDLE, unlocked, digit count < MAX_DIGITS: entry_val <= entry_val*10 + d and count++ the next cycle; leading zeros count as digits.
REQ-021 A digit at count = MAX_DIGITS SHALL be ignored (entry_val unchanged).
REQ-022 ESC in IDLE, unlocked: entry_val <= 0 and count <= 0.
REQ-023 ENT in IDLE, unlocked: length_mm <= entry_val, entry_val <= 0 and count <= 0 in the same edge.
REQ-024 GO in IDLE, unlocked, length_mm = 0: err=1 for one cycle and stay IDLE.
REQ-025 GO in IDLE, unlocked, length_mm > 0: motor_steps <= length_mm*STEPS_PER_MM (zero-extended to 32 bits, no truncation), motor_start=1 for exactly the next cycle, state <= FEED.
REQ-026 FEED, on motor_done: state <= CUT and cut_req=1 from the next cycle.
REQ-027 CUT, on cut_done: state <= IDLE and cut_req=0 from the next cycle.
REQ-028 STOP in FEED or CUT: state <= IDLE, cut_req <= 0, motor_abort=1 for one cycle; length_mm and motor_steps retained.
REQ-029 STOP in IDLE: no effect.
REQ-030 STOP together with motor_done (FEED) or cut_done (CUT) in the same cycle: STOP wins and cut_req is never asserted or is dropped.
REQ-031 LOCK in IDLE toggles locked; LOCK in FEED/CUT is ignored.
REQ-032 While locked: digits, ESC, ENT and GO ignored without err; STOP, LOCK and PWR honoured.
REQ-033 PWR in any state: all registers return to reset values the next cycle; motor_abort=1 for one cycle if the state was FEED or CUT.
REQ-034 In FEED/CUT all keys except STOP and PWR SHALL be ignored.
REQ-035 motor_done outside FEED and cut_done outside CUT SHALL be ignored.
REQ-036 busy SHALL be combinational from the state register.

Reset
REQ-037 While reset=1 at an edge: state IDLE; entry_val, length_mm, motor_steps, count all 0; motor_start, motor_abort, cut_req, locked, err all 0; reset takes priority over every input, including mid-FEED/CUT, and produces no motor_abort pulse.

Verification
REQ-038 Keys 1,2,5,ENT then GO -> length_mm=125, motor_steps=2000, one motor_start pulse, busy=1; motor_done -> cut_req=1; cut_done -> IDLE, cut_req=0.
REQ-039 Keys 9,9,9,9,7 -> entry_val=9999 (fifth digit ignored); ESC -> entry_val=0.
REQ-040 GO after reset with length_mm=0 -> err pulse, state IDLE, no motor_start.
REQ-041 In FEED, STOP and motor_done in the same cycle -> IDLE, motor_abort pulse, cut_req stays 0, length_mm retained.
REQ-042 LOCK, then 5, ENT, GO -> entry_val=0, no motor_start, no err; LOCK again -> locked=0.
REQ-043 reset asserted in CUT -> all outputs at reset values next cycle, no motor_abort pulse.
